// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the dmem arbiter and related blocks.
package dmem_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int STAT_W = 16;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way combinational picker: round-robin on conflict, or fixed priority
// to requester 0 when FIXED_PRI is set.
module rr_pick2 #(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_valid,
    output logic o_winner
);

    // Winner selection; a lone requester always wins.
    always_comb begin
        o_valid  = i_req0 | i_req1;
        o_winner = 1'b0;
        if (i_req0 && i_req1) begin
            o_winner = FIXED_PRI ? 1'b0 : ~i_last_grant;
        end else if (i_req1) begin
            o_winner = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester dmem arbiter: CPU data port (0) and loader/debug port (1).
// One access in flight; grant in IDLE, memory cycle in ACCESS, read data
// returned one cycle later with an rvalid pulse to the owner.
// Optional: define DMEM_ARBITER_STATS_EN to add saturating grant/conflict
// counters (cnt_gnt0, cnt_gnt1, cnt_conflict).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int n         = 16,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [n-1:0] adr0,
    input  logic [n-1:0] adr1,
    input  logic [n-1:0] wd0,
    input  logic [n-1:0] wd1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         rvalid0,
    output logic         rvalid1,
    output logic [n-1:0] rdata,
    output logic         mem_we,
    output logic [n-1:0] mem_adr,
    output logic [n-1:0] mem_wd,
    input  logic [n-1:0] mem_rd
`ifdef DMEM_ARBITER_STATS_EN
    ,
    output logic [STAT_W-1:0] cnt_gnt0,
    output logic [STAT_W-1:0] cnt_gnt1,
    output logic [STAT_W-1:0] cnt_conflict
`endif
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_owner;
    logic         r_last;
    logic         r_we;
    logic [n-1:0] r_adr;
    logic [n-1:0] r_wd;
    logic [n-1:0] r_rdata;
    logic         r_rvalid0;
    logic         r_rvalid1;

    logic         w_pick_valid;
    logic         w_pick_winner;
    logic         w_grant;

    rr_pick2 #(
        .FIXED_PRI (FIXED_PRI)
    ) u_pick (
        .i_req0       (req0),
        .i_req1       (req1),
        .i_last_grant (r_last),
        .o_valid      (w_pick_valid),
        .o_winner     (w_pick_winner)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and grant decode; grants only ever issue from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid && !reset) begin
                    w_grant     = 1'b1;
                    gnt0        = (w_pick_winner == REQ_CPU);
                    gnt1        = (w_pick_winner == REQ_DBG);
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Capture the winner's command and remember who was granted last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= REQ_CPU;
            r_last  <= REQ_DBG;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wd    <= '0;
        end else if (w_grant) begin
            r_owner <= w_pick_winner;
            r_last  <= w_pick_winner;
            r_we    <= (w_pick_winner == REQ_DBG) ? we1  : we0;
            r_adr   <= (w_pick_winner == REQ_DBG) ? adr1 : adr0;
            r_wd    <= (w_pick_winner == REQ_DBG) ? wd1  : wd0;
        end
    end

    // Read completion: latch memory data and pulse the owner's rvalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata   <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            if (r_state == ACCESS && !r_we) begin
                r_rdata   <= mem_rd;
                r_rvalid0 <= (r_owner == REQ_CPU);
                r_rvalid1 <= (r_owner == REQ_DBG);
            end
        end
    end

    // mem_we follows the state register, so a reset drops it at once.
    assign mem_we  = (r_state == ACCESS) && r_we;
    assign mem_adr = r_adr;
    assign mem_wd  = r_wd;
    assign rdata   = r_rdata;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;

`ifdef DMEM_ARBITER_STATS_EN
    logic [STAT_W-1:0] r_cnt_gnt0;
    logic [STAT_W-1:0] r_cnt_gnt1;
    logic [STAT_W-1:0] r_cnt_conflict;

    // Saturating usage counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_gnt0     <= '0;
            r_cnt_gnt1     <= '0;
            r_cnt_conflict <= '0;
        end else begin
            if (gnt0 && r_cnt_gnt0 != '1) begin
                r_cnt_gnt0 <= r_cnt_gnt0 + STAT_W'(1);
            end
            if (gnt1 && r_cnt_gnt1 != '1) begin
                r_cnt_gnt1 <= r_cnt_gnt1 + STAT_W'(1);
            end
            if (r_state == IDLE && req0 && req1 && r_cnt_conflict != '1) begin
                r_cnt_conflict <= r_cnt_conflict + STAT_W'(1);
            end
        end
    end

    assign cnt_gnt0     = r_cnt_gnt0;
    assign cnt_gnt1     = r_cnt_gnt1;
    assign cnt_conflict = r_cnt_conflict;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus short
// hand-written sequences for conflicts, fixed priority and mid-access reset.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [15:0] adr0, adr1, wd0, wd1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [15:0] rdata, mem_adr, mem_wd, mem_rd;
    logic        fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_mem_we;
    logic [15:0] fp_rdata, fp_mem_adr, fp_mem_wd, fp_mem_rd;
`ifdef DMEM_ARBITER_STATS_EN
    logic [15:0] cnt_gnt0, cnt_gnt1, cnt_conflict;
    logic [15:0] fp_cnt_gnt0, fp_cnt_gnt1, fp_cnt_conflict;
`endif

    logic [15:0] mem    [0:255];
    logic [15:0] mem_fp [0:255];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.n(16), .FIXED_PRI(1'b0)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .adr0(adr0), .adr1(adr1), .wd0(wd0), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
`ifdef DMEM_ARBITER_STATS_EN
        , .cnt_gnt0(cnt_gnt0), .cnt_gnt1(cnt_gnt1), .cnt_conflict(cnt_conflict)
`endif
    );

    dmem_arbiter #(.n(16), .FIXED_PRI(1'b1)) u_dut_fp (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .adr0(adr0), .adr1(adr1), .wd0(wd0), .wd1(wd1),
        .gnt0(fp_gnt0), .gnt1(fp_gnt1), .rvalid0(fp_rvalid0), .rvalid1(fp_rvalid1),
        .rdata(fp_rdata), .mem_we(fp_mem_we), .mem_adr(fp_mem_adr), .mem_wd(fp_mem_wd),
        .mem_rd(fp_mem_rd)
`ifdef DMEM_ARBITER_STATS_EN
        , .cnt_gnt0(fp_cnt_gnt0), .cnt_gnt1(fp_cnt_gnt1), .cnt_conflict(fp_cnt_conflict)
`endif
    );

    // Word-addressed dmem models: combinational read, write on posedge.
    assign mem_rd    = mem[mem_adr[9:2]];
    assign fp_mem_rd = mem_fp[fp_mem_adr[9:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_adr[9:2]] <= mem_wd;
        if (fp_mem_we) mem_fp[fp_mem_adr[9:2]] <= fp_mem_wd;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                         input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1);
        req0 = r0; we0 = w0; adr0 = a0; wd0 = d0;
        req1 = r1; we1 = w1; adr1 = a1; wd1 = d1;
    endtask

    typedef struct {
        logic        r0, w0;
        logic [15:0] a0, d0;
        logic        r1, w1;
        logic [15:0] a1, d1;
        logic        g0, g1, v0, v1, we;
        logic [15:0] adr, rd;
    } vec_t;

    vec_t tbl [17];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 16'h0000;
            mem_fp[i] = 16'h0000;
        end
        mem[0] = 16'h1111;  mem_fp[0] = 16'h1111;
        mem[1] = 16'hBEEF;  mem_fp[1] = 16'hBEEF;

        //            r0 w0 a0       d0       r1 w1 a1       d1        g0 g1 v0 v1 we adr      rd
        tbl[0]  = '{1'b1,1'b0,16'h0004,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000};
        tbl[1]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,16'h0004,16'h0000};
        tbl[2]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b1,1'b0,1'b0,16'h0004,16'hBEEF};
        tbl[3]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b1,16'h0008,16'h1234, 1'b0,1'b1,1'b0,1'b0,1'b0,16'h0004,16'hBEEF};
        tbl[4]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b1,16'h0008,16'hBEEF};
        tbl[5]  = '{1'b1,1'b0,16'h0008,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b0,16'h0008,16'hBEEF};
        tbl[6]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'h0004,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,16'h0008,16'hBEEF};
        tbl[7]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'h0004,16'h0000, 1'b0,1'b1,1'b1,1'b0,1'b0,16'h0008,16'h1234};
        tbl[8]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,16'h0004,16'h1234};
        tbl[9]  = '{1'b1,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'h0008,16'h0000, 1'b1,1'b0,1'b0,1'b1,1'b0,16'h0004,16'hBEEF};
        tbl[10] = '{1'b1,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'h0008,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'hBEEF};
        tbl[11] = '{1'b1,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'h0008,16'h0000, 1'b0,1'b1,1'b1,1'b0,1'b0,16'h0000,16'h1111};
        tbl[12] = '{1'b1,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'h0008,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,16'h0008,16'h1111};
        tbl[13] = '{1'b1,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'h0008,16'h0000, 1'b1,1'b0,1'b0,1'b1,1'b0,16'h0008,16'h1234};
        tbl[14] = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h1234};
        tbl[15] = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,16'h1111};
        tbl[16] = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h1111};

        // Reset state, with a pending request that must not be granted.
        reset = 1'b1;
        drive(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        chk("rst_gnt0",    gnt0,    1'b0);
        chk("rst_gnt1",    gnt1,    1'b0);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_rdata",   rdata,   16'h0000);
        chk("rst_mem_we",  mem_we,  1'b0);
        chk("rst_mem_adr", mem_adr, 16'h0000);
        chk("rst_mem_wd",  mem_wd,  16'h0000);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #11 reset = 1'b0;
        next_cycle();

        // Per-cycle vector table.
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                  tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            #1;
            chk($sformatf("v%0d_gnt0", i),    gnt0,    tbl[i].g0);
            chk($sformatf("v%0d_gnt1", i),    gnt1,    tbl[i].g1);
            chk($sformatf("v%0d_rvalid0", i), rvalid0, tbl[i].v0);
            chk($sformatf("v%0d_rvalid1", i), rvalid1, tbl[i].v1);
            chk($sformatf("v%0d_mem_we", i),  mem_we,  tbl[i].we);
            chk($sformatf("v%0d_mem_adr", i), mem_adr, tbl[i].adr);
            chk($sformatf("v%0d_rdata", i),   rdata,   tbl[i].rd);
            next_cycle();
        end
        chk("mem_word2_written", mem[2], 16'h1234);

`ifdef DMEM_ARBITER_STATS_EN
        chk("stats_gnt0",     cnt_gnt0,     16'd4);
        chk("stats_gnt1",     cnt_gnt1,     16'd3);
        chk("stats_conflict", cnt_conflict, 16'd3);
        chk("stats_gnt_sum",  32'(cnt_gnt0) + 32'(cnt_gnt1), 32'd7);
`endif

        // Continuous conflicting reads from a fresh reset: round-robin
        // alternates 0,1,0,1; the fixed-priority instance only grants 0.
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        next_cycle();
        drive(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b1, 1'b0, 16'h0008, 16'h0000);
        for (int j = 0; j < 8; j++) begin
            #1;
            chk($sformatf("rr%0d_gnt0", j),    gnt0,    (j % 4) == 0);
            chk($sformatf("rr%0d_gnt1", j),    gnt1,    (j % 4) == 2);
            chk($sformatf("rr%0d_rvalid0", j), rvalid0, (j % 4) == 2);
            chk($sformatf("rr%0d_rvalid1", j), rvalid1, j >= 4 && (j % 4) == 0);
            if (j == 2) chk("rr_rdata_req0", rdata, 16'hBEEF);
            if (j == 4) chk("rr_rdata_req1", rdata, 16'h1234);
            chk($sformatf("fp%0d_gnt0", j),    fp_gnt0,    (j % 2) == 0);
            chk($sformatf("fp%0d_gnt1", j),    fp_gnt1,    1'b0);
            chk($sformatf("fp%0d_rvalid1", j), fp_rvalid1, 1'b0);
            next_cycle();
        end
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        next_cycle();
        next_cycle();

        // Reset in the middle of a write access.
        drive(1'b1, 1'b1, 16'h000C, 16'h5555, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        chk("wr_gnt0", gnt0, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        chk("wr_access_mem_we", mem_we, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_mem_we", mem_we, 1'b0);
        #2 reset = 1'b0;
        next_cycle();
        chk("midrst_rvalid0", rvalid0, 1'b0);
        chk("midrst_rvalid1", rvalid1, 1'b0);
        chk("midrst_no_write", mem[3], 16'h0000);

        // Arbiter is back in IDLE and grants the next request normally.
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0004, 16'h0000);
        #1;
        chk("post_gnt1", gnt1, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        chk("post_mem_adr", mem_adr, 16'h0004);
        chk("post_mem_we",  mem_we,  1'b0);
        next_cycle();
        chk("post_rvalid1", rvalid1, 1'b1);
        chk("post_rvalid0", rvalid0, 1'b0);
        chk("post_rdata",   rdata,   16'hBEEF);
        next_cycle();
        chk("post_rdata_hold", rdata, 16'hBEEF);
        chk("post_rvalid1_pulse", rvalid1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
